// File: rtl/mux16_rr_arbiter.sv
// rtl/mux16_rr_arbiter.sv - burst-limited round-robin arbiter driving a 16:1 mux select
// Registered grant/sel/out_valid/beat_cnt; priority rotates from the last granted index.
module mux16_rr_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int CW        = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   req,
  input  logic          out_ready,
  output logic [3:0]    sel,
  output logic [15:0]   grant,
  output logic          out_valid,
  output logic [CW-1:0] beat_cnt
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  state_t        state_q, state_d;
  logic [3:0]    ptr_q, ptr_d;
  logic [3:0]    sel_q, sel_d;
  logic [15:0]   grant_q, grant_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          win_found;
  logic [3:0]    win_idx;
  logic [3:0]    cand;
  logic          accept;

  // Scan ptr+1 .. ptr+16 (mod 16); the last-granted index is checked last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 4'd0;
    cand      = 4'd0;
    for (int i = 1; i <= 16; i++) begin
      cand = ptr_q + 4'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign accept = valid_q && out_ready && req[sel_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, GAP: begin
        cnt_d = '0;
        if (win_found) begin
          state_d = GRANT;
          sel_d   = win_idx;
          grant_d = 16'd1 << win_idx;
          valid_d = 1'b1;
        end else begin
          state_d = IDLE;
          sel_d   = 4'd0;
          grant_d = '0;
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        // Withdrawal wins over a beat: no count when req[sel] has dropped.
        if (!req[sel_q] || (accept && cnt_q == LAST_BEAT)) begin
          state_d = GAP;
          ptr_d   = sel_q;
          grant_d = '0;
          valid_d = 1'b0;
          cnt_d   = '0;
        end else if (accept) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 4'd0;
        grant_d = '0;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 4'd15;
      sel_q   <= 4'd0;
      grant_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel       = sel_q;
  assign grant     = grant_q;
  assign out_valid = valid_q;
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb/tb_mux16_rr_arbiter.sv - directed-vector bench for mux16_rr_arbiter
module tb_mux16_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic        out_ready;
  logic [3:0]  sel;
  logic [15:0] grant;
  logic        out_valid;
  logic [7:0]  beat_cnt;

  int checks   = 0;
  int failures = 0;

  mux16_rr_arbiter #(.BURST_LEN(4), .CW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .out_ready (out_ready),
    .sel       (sel),
    .grant     (grant),
    .out_valid (out_valid),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] s, input logic [7:0] c);
    logic [15:0] g;
    g = v ? (16'd1 << s) : 16'd0;
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".sel"},   32'(sel), 32'(s));
    check({tag, ".cnt"},   32'(beat_cnt), 32'(c));
  endtask

  task automatic burst(input string tag, input logic [3:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      chk_out(tag, 1'b1, s, 8'(i));
      tick();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 16'h0000;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 16'h0001;
    out_ready = 1'b1;
    @(negedge clk);

    // Reset priority
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("rst_hold", 1'b0, 4'd0, 8'd0);
    end
    rst_n = 1'b1;
    tick();
    burst("rst_b0", 4'd0, 4);
    chk_out("rst_gap", 1'b0, 4'd0, 8'd0);
    tick();
    chk_out("rst_regrant", 1'b1, 4'd0, 8'd0);
    req = 16'h0000;
    tick();
    chk_out("rst_wd_gap", 1'b0, 4'd0, 8'd0);
    tick();
    chk_out("rst_idle", 1'b0, 4'd0, 8'd0);

    // Rotation 0 -> 8 -> 15 -> 0
    do_reset();
    req = 16'h8101;
    tick();
    burst("rot_b0", 4'd0, 4);
    chk_out("rot_gap0", 1'b0, 4'd0, 8'd0);
    tick();
    burst("rot_b8", 4'd8, 4);
    chk_out("rot_gap8", 1'b0, 4'd8, 8'd0);
    tick();
    burst("rot_b15", 4'd15, 4);
    chk_out("rot_gap15", 1'b0, 4'd15, 8'd0);
    tick();
    chk_out("rot_wrap0", 1'b1, 4'd0, 8'd0);

    // Wrap-around from ptr=14
    do_reset();
    req = 16'h4000;
    tick();
    burst("wrap_b14a", 4'd14, 4);
    chk_out("wrap_gap14a", 1'b0, 4'd14, 8'd0);
    req = 16'h4003;
    tick();
    burst("wrap_b0", 4'd0, 4);
    chk_out("wrap_gap0", 1'b0, 4'd0, 8'd0);
    tick();
    burst("wrap_b1", 4'd1, 4);
    chk_out("wrap_gap1", 1'b0, 4'd1, 8'd0);
    tick();
    burst("wrap_b14b", 4'd14, 4);
    chk_out("wrap_gap14b", 1'b0, 4'd14, 8'd0);
    req = 16'h0000;
    tick();
    chk_out("wrap_idle", 1'b0, 4'd0, 8'd0);

    // Stall mid-burst
    do_reset();
    req = 16'h0020;
    tick();
    burst("stall_pre", 4'd5, 2);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk_out("stall_hold", 1'b1, 4'd5, 8'd2);
      tick();
    end
    out_ready = 1'b1;
    chk_out("stall_resume2", 1'b1, 4'd5, 8'd2);
    tick();
    chk_out("stall_resume3", 1'b1, 4'd5, 8'd3);
    tick();
    chk_out("stall_gap", 1'b0, 4'd5, 8'd0);
    req = 16'h0000;
    tick();
    chk_out("stall_idle", 1'b0, 4'd0, 8'd0);

    // Withdrawal
    do_reset();
    req = 16'h0008;
    tick();
    burst("wd_b3", 4'd3, 1);
    req = 16'h0080;
    chk_out("wd_drop", 1'b1, 4'd3, 8'd1);
    tick();
    chk_out("wd_gap", 1'b0, 4'd3, 8'd0);
    tick();
    chk_out("wd_g7", 1'b1, 4'd7, 8'd0);
    req = 16'h0000;
    tick();
    chk_out("wd_gap7", 1'b0, 4'd7, 8'd0);

    // Reset mid-grant; ptr was 7 so a stale pointer would pick 9 over 4
    req = 16'h0200;
    tick();
    burst("mrst_b9", 4'd9, 2);
    chk_out("mrst_beat2", 1'b1, 4'd9, 8'd2);
    rst_n = 1'b0;
    req   = 16'h0210;
    tick();
    chk_out("mrst_clear", 1'b0, 4'd0, 8'd0);
    rst_n = 1'b1;
    tick();
    chk_out("mrst_g4", 1'b1, 4'd4, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
